// File: rtl/debug_pkg.sv
// Shared definitions for the debug monitor: display/ASCII glyph helpers,
// frame delimiter characters and the dump FSM state type.
package debug_pkg;

  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } dump_state_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/debug_monitor_if.sv
// Byte-wide UART transmit handshake between the debug monitor and the uart TX block.
interface debug_monitor_if;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;

  modport master (output tx_data, output tx_we, input tx_busy);
  modport slave  (input tx_data, input tx_we, output tx_busy);
endinterface

// File: rtl/debug_monitor_seg_scan_driver.sv
// Multiplexed 7-segment scanner: one digit slot per SCAN_DIV clocks, registered seg/anode.
module seg_scan_driver
  import debug_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  tc;
  logic [3:0]            nib;

  // The output pair is loaded at the end of each slot, so the first lit digit is index 0.
  always_comb begin
    tc      = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d   = tc ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    seg_d   = seg_q;
    anode_d = anode_q;
    nib     = digits[4*int'(idx_q) +: 4];
    if (tc) begin
      seg_d   = hex_glyph(nib);
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      anode_q <= '1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign seg   = seg_q;
  assign anode = anode_q;

endmodule

// File: rtl/debug_monitor.sv
// On-board debug monitor: probe select, freeze snapshot, paged 7-seg display
// and a UART hex dump of the displayed probe word.
module debug_monitor
  import debug_pkg::*;
#(
  parameter int  NUM_PROBES = 8,
  parameter int  PROBE_W    = 32,
  parameter int  NUM_DIGITS = 4,
  parameter int  SCAN_DIV   = 100000,
  localparam int PAGES      = PROBE_W / (4*NUM_DIGITS),
  localparam int SEL_W      = $clog2(NUM_PROBES),
  localparam int PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]              sel,
  input  logic [PAGE_W-1:0]             page,
  input  logic                          freeze,
  input  logic                          dump_req,
  debug_monitor_if.master               uart,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [1:0]                    led
);

  localparam int NIBS      = PROBE_W / 4;
  localparam int FRAME     = NIBS + 4;
  localparam int CNT_W     = $clog2(FRAME);
  localparam int PAGE_BITS = 4 * NUM_DIGITS;

  logic [SEL_W-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [PAGE_W-1:0]  page_s1_q, page_s1_d, page_s2_q, page_s2_d;
  logic               frz_s1_q, frz_s1_d, frz_s2_q, frz_s2_d, frz_prev_q, frz_prev_d;
  logic [PROBE_W-1:0] snap_q, snap_d;

  dump_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROBE_W-1:0] dword_q, dword_d;
  logic [SEL_W-1:0]   dsel_q, dsel_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_we_q, tx_we_d;
  logic               first_q, first_d;

  logic [PROBE_W-1:0]   live, disp;
  logic [PAGE_BITS-1:0] page_word;
  logic                 frz_edge;
  int                   pg;
  logic [7:0]           frame_byte;

  always_comb begin
    sel_s1_d   = sel;
    sel_s2_d   = sel_s1_q;
    page_s1_d  = page;
    page_s2_d  = page_s1_q;
    frz_s1_d   = freeze;
    frz_s2_d   = frz_s1_q;
    frz_prev_d = frz_s2_q;
  end

  // In the edge cycle the snapshot is not loaded yet, so live is still what is shown.
  always_comb begin
    live = '0;
    for (int k = 0; k < NUM_PROBES; k++) begin
      if (sel_s2_q == SEL_W'(k)) live = probe_bus[k*PROBE_W +: PROBE_W];
    end
    frz_edge  = frz_s2_q & ~frz_prev_q;
    snap_d    = frz_edge ? live : snap_q;
    disp      = (frz_s2_q & ~frz_edge) ? snap_q : live;
    pg        = (int'(page_s2_q) < PAGES) ? int'(page_s2_q) : 0;
    page_word = disp[pg*PAGE_BITS +: PAGE_BITS];
  end

  always_comb begin
    frame_byte = CHR_LF;
    if (cnt_q == '0)
      frame_byte = hex_ascii(4'(dsel_q));
    else if (cnt_q == CNT_W'(1))
      frame_byte = CHR_COLON;
    else if (int'(cnt_q) <= NIBS + 1)
      frame_byte = hex_ascii(dword_q[4*(NIBS + 1 - int'(cnt_q)) +: 4]);
    else if (int'(cnt_q) == NIBS + 2)
      frame_byte = CHR_CR;
  end

  // first_q marks the WAIT cycle in which the uart has not yet raised busy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dword_d   = dword_q;
    dsel_d    = dsel_q;
    tx_data_d = tx_data_q;
    tx_we_d   = 1'b0;
    first_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          dword_d = disp;
          dsel_d  = sel_s2_q;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = frame_byte;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!uart.tx_busy) begin
          tx_we_d = 1'b1;
          first_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!first_q && !uart.tx_busy) begin
          if (cnt_q == CNT_W'(FRAME - 1)) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      page_s1_q  <= '0;
      page_s2_q  <= '0;
      frz_s1_q   <= 1'b0;
      frz_s2_q   <= 1'b0;
      frz_prev_q <= 1'b0;
      snap_q     <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dword_q    <= '0;
      dsel_q     <= '0;
      tx_data_q  <= '0;
      tx_we_q    <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      sel_s1_q   <= sel_s1_d;
      sel_s2_q   <= sel_s2_d;
      page_s1_q  <= page_s1_d;
      page_s2_q  <= page_s2_d;
      frz_s1_q   <= frz_s1_d;
      frz_s2_q   <= frz_s2_d;
      frz_prev_q <= frz_prev_d;
      snap_q     <= snap_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dword_q    <= dword_d;
      dsel_q     <= dsel_d;
      tx_data_q  <= tx_data_d;
      tx_we_q    <= tx_we_d;
      first_q    <= first_d;
    end
  end

  assign uart.tx_data = tx_data_q;
  assign uart.tx_we   = tx_we_q;
  assign led          = {frz_s2_q, state_q != S_IDLE};

  seg_scan_driver #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .digits (page_word),
    .seg    (seg),
    .anode  (anode)
  );

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench: default-size monitor (A) and a 16x16-bit monitor (B), SCAN_DIV=4.
module tb_debug_monitor;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [255:0]  probe_a = '0;
  logic [2:0]    sel_a = '0;
  logic [0:0]    page_a = '0;
  logic          freeze_a = 1'b0;
  logic          dump_a = 1'b0;
  logic [6:0]    seg_a;
  logic [3:0]    anode_a;
  logic [1:0]    led_a;

  logic [255:0]  probe_b = '0;
  logic [3:0]    sel_b = '0;
  logic [0:0]    page_b = '0;
  logic          freeze_b = 1'b0;
  logic          dump_b = 1'b0;
  logic [6:0]    seg_b;
  logic [3:0]    anode_b;
  logic [1:0]    led_b;

  debug_monitor_if bus_a();
  debug_monitor_if bus_b();

  int tests = 0;
  int fails = 0;
  int busy_a = 0, busy_b = 0;
  int viol_a = 0, viol_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  logic [7:0] exp_a [12] = '{8'h35, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44,
                             8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] exp_b [8]  = '{8'h46, 8'h3A, 8'h30, 8'h30, 8'h46, 8'h30, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  debug_monitor #(.NUM_PROBES(8), .PROBE_W(32), .NUM_DIGITS(4), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .probe_bus(probe_a), .sel(sel_a), .page(page_a),
    .freeze(freeze_a), .dump_req(dump_a), .uart(bus_a.master),
    .seg(seg_a), .anode(anode_a), .led(led_a));

  debug_monitor #(.NUM_PROBES(16), .PROBE_W(16), .NUM_DIGITS(4), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .probe_bus(probe_b), .sel(sel_b), .page(page_b),
    .freeze(freeze_b), .dump_req(dump_b), .uart(bus_b.master),
    .seg(seg_b), .anode(anode_b), .led(led_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the uart models answer each strobe with 10 busy cycles.
  task automatic step();
    @(negedge clk);
    if (bus_a.tx_we) begin
      if (bus_a.tx_busy) viol_a++;
      q_a.push_back(bus_a.tx_data);
      busy_a = 10;
    end else if (busy_a > 0) busy_a--;
    bus_a.tx_busy = (busy_a != 0);
    if (bus_b.tx_we) begin
      if (bus_b.tx_busy) viol_b++;
      q_b.push_back(bus_b.tx_data);
      busy_b = 10;
    end else if (busy_b > 0) busy_b--;
    bus_b.tx_busy = (busy_b != 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_digit(input bit use_b, input int idx, input logic [6:0] exp_seg, input string tag);
    logic [3:0] want;
    want = ~(4'b0001 << idx);
    for (int i = 0; i < 40; i++) begin
      if ((use_b ? anode_b : anode_a) == want) break;
      step();
    end
    chk({tag, " anode"}, use_b ? anode_b : anode_a, want);
    chk({tag, " seg"}, use_b ? seg_b : seg_a, exp_seg);
  endtask

  task automatic pulse_dump(input bit use_b);
    if (use_b) dump_b = 1'b1; else dump_a = 1'b1;
    step();
    dump_a = 1'b0;
    dump_b = 1'b0;
  endtask

  task automatic wait_dump_done(input bit use_b);
    for (int i = 0; i < 1000; i++) begin
      if (!(use_b ? led_b[0] : led_a[0])) break;
      step();
    end
    chk("dump done led0", use_b ? led_b[0] : led_a[0], 1'b0);
  endtask

  initial begin
    bus_a.tx_busy = 1'b0;
    bus_b.tx_busy = 1'b0;
    probe_a[3*32 +: 32]  = 32'h1234_ABCD;
    probe_a[5*32 +: 32]  = 32'hDEAD_BEEF;
    sel_a                = 3'd3;
    probe_b[15*16 +: 16] = 16'h00F0;
    sel_b                = 4'd15;
    page_b               = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("reset seg", seg_a, 7'h7F);
      chk("reset anode", anode_a, 4'hF);
      chk("reset tx_we", bus_a.tx_we, 1'b0);
    end
    chk("reset led", led_a, 2'b00);
    chk("reset tx_data", bus_a.tx_data, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-reset anode", anode_a, 4'hF);
      chk("post-reset seg", seg_a, 7'h7F);
    end
    step();
    chk("first anode", anode_a, 4'hE);
    chk("first seg", seg_a, 7'h21);
    check_digit(0, 1, 7'h46, "p0 d1");
    check_digit(0, 2, 7'h03, "p0 d2");
    check_digit(0, 3, 7'h08, "p0 d3");

    page_a = 1'b1;
    steps(20);
    check_digit(0, 0, 7'h19, "p1 d0");
    check_digit(0, 1, 7'h30, "p1 d1");
    check_digit(0, 2, 7'h24, "p1 d2");
    check_digit(0, 3, 7'h79, "p1 d3");
    page_a = 1'b0;

    freeze_a = 1'b1;
    steps(4);
    probe_a[3*32 +: 32] = 32'h0;
    steps(20);
    chk("frozen led1", led_a[1], 1'b1);
    check_digit(0, 0, 7'h21, "frz d0");
    check_digit(0, 1, 7'h46, "frz d1");
    check_digit(0, 2, 7'h03, "frz d2");
    check_digit(0, 3, 7'h08, "frz d3");
    freeze_a = 1'b0;
    steps(18);
    chk("unfrozen led1", led_a[1], 1'b0);
    for (int d = 0; d < 4; d++) check_digit(0, d, 7'h40, "unfrz");

    sel_a = 3'd5;
    steps(4);
    q_a.delete();
    pulse_dump(0);
    chk("dump led0 busy", led_a[0], 1'b1);
    steps(30);
    pulse_dump(0);
    wait_dump_done(0);
    chk("dump count at led0 fall", q_a.size(), 12);
    steps(30);
    chk("dump count after extra req", q_a.size(), 12);
    for (int i = 0; i < 12; i++) chk("dump byte", (i < q_a.size()) ? q_a[i] : 8'hxx, exp_a[i]);
    chk("tx_we while busy", viol_a, 0);

    q_a.delete();
    pulse_dump(0);
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() >= 3) break;
      step();
    end
    chk("abort bytes before rst", q_a.size(), 3);
    rst = 1'b1;
    step();
    chk("abort tx_we", bus_a.tx_we, 1'b0);
    chk("abort led0", led_a[0], 1'b0);
    step();
    rst = 1'b0;
    steps(60);
    chk("abort no more bytes", q_a.size(), 3);
    chk("abort still idle", led_a[0], 1'b0);
    q_a.delete();
    pulse_dump(0);
    wait_dump_done(0);
    chk("refresh count", q_a.size(), 12);
    for (int i = 0; i < 12; i++) chk("refresh byte", (i < q_a.size()) ? q_a[i] : 8'hxx, exp_a[i]);

    check_digit(1, 0, 7'h40, "B d0");
    check_digit(1, 1, 7'h0E, "B d1");
    check_digit(1, 2, 7'h40, "B d2");
    check_digit(1, 3, 7'h40, "B d3");
    q_b.delete();
    pulse_dump(1);
    wait_dump_done(1);
    chk("B count", q_b.size(), 8);
    for (int i = 0; i < 8; i++) chk("B byte", (i < q_b.size()) ? q_b[i] : 8'hxx, exp_b[i]);
    chk("B tx_we while busy", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
